attract_ctrl: RTL
=================

# attract_ctrl

Input-ownership controller between the paddle/start inputs and `game`. Per side, it forwards the human paddle bitmap, or replaces it with a rate-limited AI paddle after an idle timeout. When both sides are AI-driven it runs attract mode. It sequences `game` by pulsing `start` on attract entry and `game_reset` when a player takes over, so a fresh match begins.

## Interface
- `IDLE_MS`, 20000: game_clk ticks without input before a side goes AUTO; range 2..32767.
- `AI_STEP_MS`, 60: ticks between AI paddle moves; range 1..1023.
- `PADDLE_LEN`, 4: AI paddle length in rows; range 1..8.
- `game_clk` in 1: 1000 Hz game clock.
- `reset` in 1: synchronous, active-high.
- `lpaddle_in` in 16: human left paddle bitmap; bit i = row y=i.
- `rpaddle_in` in 16: human right paddle bitmap.
- `start_in` in 1: debounced start button.
- `ball_x` in 4: ball column from `game`.
- `ball_y` in 4: ball row from `game`.
- `lpaddle` out 16: left paddle bitmap to `game`.
- `rpaddle` out 16: right paddle bitmap to `game`.
- `start` out 1: start to `game`.
- `game_reset` out 1: one-cycle pulse; ORed into `game` reset at top level.
- `l_auto` out 1: left side is AI-driven.
- `r_auto` out 1: right side is AI-driven.
- `attract` out 1: `l_auto & r_auto`.

## Operation
- **Per-side state:** mode HUMAN/AUTO; 15-bit idle counter; 4-bit AI position `pos`, the bottom row of the AI paddle; 10-bit step timer; registered previous input `prev`.
- **Input change:** `*_in != prev`. `prev` updates every cycle.
- **HUMAN mode:**
  - On change, counter clears to 0; otherwise it increments, saturating at `IDLE_MS`.
  - When the counter reaches `IDLE_MS`, the side goes AUTO on that edge.
  - `pos` loads the lowest set bit index of `*_in`, clamped to [0, 16-PADDLE_LEN]. If `*_in` is 0, `pos` loads (16-PADDLE_LEN)/2.
  - Step timer clears.
- **AUTO mode:**
  - On change, the side goes HUMAN and the counter clears.
  - Otherwise the step timer counts to `AI_STEP_MS-1`, then wraps to 0 and performs one step.
  - Step target = `ball_y - PADDLE_LEN/2`, computed signed 6-bit, clamped to [0, 16-PADDLE_LEN].
  - Step direction: `pos` +1 if below target, −1 if above, hold if equal.
  - Step gate: left steps only when `ball_x <= 7`; right steps only when `ball_x >= 8`. A gated step still wraps the timer.
- **AI bitmap:** bits `pos .. pos+PADDLE_LEN-1` set, all others 0.
- **Outputs:** each paddle output is the AI bitmap when that side is AUTO, else `*_in`.
- **start_in outside attract:**
  - Forwarded to `start`.
  - Clears the idle counter of each HUMAN side.
  - Does not change any side's mode.
- **start_in during attract (attract=1):**
  - Both sides go HUMAN and both counters clear.
  - `start` = 0 that cycle (start is swallowed).
- **Attract entry (attract 0→1):** `start` pulses 1 for one cycle, so `game` skips its freeze.
- **Attract exit (attract 1→0), from any cause:** `game_reset` pulses 1 for one cycle. Scores clear and a 16 s freeze begins, which the player cuts short with start.
- **One-side exit:** if one side leaves AUTO during attract, the other side stays AUTO (one-player game) and `game_reset` still pulses.
- **Simultaneous events:**
  - An input change on the cycle the counter would saturate wins: side stays HUMAN, counter 0.
  - `start_in` together with attract entry on the same cycle: entry is suppressed, both sides HUMAN.
- **Reset:**
  - Modes HUMAN, counters 0, step timers 0, `prev` 0.
  - `pos` = (16-PADDLE_LEN)/2.
  - All outputs 0.
  - A reset mid-attract gives no `game_reset` pulse; the external reset covers `game`.

## Timing
- All outputs are registered. Paddle pass-through latency is 1 cycle (`*_in` at edge n appears at n+1).
- Mode transitions take effect on the edge where the condition is sampled. Outputs reflect the new mode from the next cycle.
- AUTO entry: an idle side goes AUTO exactly `IDLE_MS`+1 edges after its last input change.
- AI movement: at most one row per `AI_STEP_MS` cycles. The first step comes `AI_STEP_MS` cycles after AUTO entry.
- Pulse timing: the `start` and `game_reset` pulses are exactly 1 cycle wide and appear in the cycle after `attract` changes.

## Test plan
All scenarios use IDLE_MS=20, AI_STEP_MS=4, PADDLE_LEN=4.

1. **Pass-through:** reset, then `lpaddle_in`=16'h00F0 → `lpaddle`=16'h00F0 one cycle later; `l_auto`=0.
2. **Left idle takeover:** hold `lpaddle_in`=16'h0F00 unchanged for 21 cycles, `ball_y`=2, `ball_x`=3.
   - `l_auto`=1, `pos`=8, `lpaddle`=16'h0F00.
   - Then one row down every 4 cycles: 16'h0780, ... , until 16'h000F (target 0).
3. **Step gating:** as scenario 2 but `ball_x`=12 → left `pos` holds at 8 indefinitely. Switch `ball_x` to 5 → next timer wrap steps to 7.
4. **Attract entry:** both inputs static for 21 cycles → `attract`=1, `start`=1 for exactly one cycle, then 0.
5. **Start in attract:** `start_in`=1 in attract → `l_auto`=`r_auto`=0, `start`=0 that cycle, `game_reset`=1 for one cycle, paddles show `*_in` next cycle.
6. **Counter race:** `rpaddle_in` changes on the cycle its counter would hit 20 → `r_auto` stays 0 and the counter restarts; AUTO is reached 21 cycles later. Separately, assert `reset` mid-attract → all outputs 0 and no `game_reset` pulse.

Source files
------------

// File: rtl/attract_ctrl_if.sv
// attract_ctrl_if
// Groups the paddle/start/ball signals between the input front end, the
// attract controller and the game core.
//   lpaddle_in, rpaddle_in : human paddle bitmaps (bit i = row i)
//   start_in               : debounced start button
//   ball_x, ball_y         : ball position reported by the game core
//   lpaddle, rpaddle       : paddle bitmaps forwarded to the game core
//   start, game_reset      : sequencing strobes to the game core
//   l_auto, r_auto, attract: ownership status
// master drives the inputs and observes the outputs; slave is the controller.
interface attract_ctrl_if;
    logic [15:0] lpaddle_in;
    logic [15:0] rpaddle_in;
    logic        start_in;
    logic [3:0]  ball_x;
    logic [3:0]  ball_y;
    logic [15:0] lpaddle;
    logic [15:0] rpaddle;
    logic        start;
    logic        game_reset;
    logic        l_auto;
    logic        r_auto;
    logic        attract;

    modport master (
        output lpaddle_in, rpaddle_in, start_in, ball_x, ball_y,
        input  lpaddle, rpaddle, start, game_reset, l_auto, r_auto, attract
    );

    modport slave (
        input  lpaddle_in, rpaddle_in, start_in, ball_x, ball_y,
        output lpaddle, rpaddle, start, game_reset, l_auto, r_auto, attract
    );
endinterface

// File: rtl/attract_ctrl.sv
// attract_ctrl
// Decides per side whether the human paddle bitmap or a rate-limited AI
// paddle drives the game core, runs attract mode when both sides are AI,
// and sequences the game core with start / game_reset strobes.
// Ports:
//   game_clk : 1 kHz game clock
//   reset    : synchronous, active-high
//   bus      : attract_ctrl_if.slave (paddles, start, ball position, status)
//
// Per-side mode FSM (index 0 = left, 1 = right)
//   state      | meaning
//   MODE_HUMAN | paddle input forwarded, idle counter running
//   MODE_AUTO  | AI paddle tracks ball_y one row per AI_STEP_MS ticks
module attract_ctrl #(
    parameter int IDLE_MS    = 20000,
    parameter int AI_STEP_MS = 60,
    parameter int PADDLE_LEN = 4
) (
    input  logic          game_clk,
    input  logic          reset,
    attract_ctrl_if.slave bus
);
    localparam logic [0:0]        MODE_HUMAN = 1'b0;
    localparam logic [0:0]        MODE_AUTO  = 1'b1;
    localparam logic [3:0]        POS_MAX    = 4'(16 - PADDLE_LEN);
    localparam logic signed [5:0] POS_MAX_S  = 6'(16 - PADDLE_LEN);
    localparam logic [3:0]        POS_MID    = 4'((16 - PADDLE_LEN) / 2);
    localparam logic signed [5:0] HALF_LEN   = 6'(PADDLE_LEN / 2);
    localparam logic [14:0]       IDLE_TC    = 15'(IDLE_MS);
    localparam logic [9:0]        STEP_TC    = 10'(AI_STEP_MS - 1);
    localparam logic [15:0]       AI_MASK    = 16'((1 << PADDLE_LEN) - 1);

    logic [15:0]       pin      [2];
    logic              gate     [2];
    logic [0:0]        mode_q   [2];
    logic [0:0]        mode_n   [2];
    logic [14:0]       cnt_q    [2];
    logic [14:0]       cnt_n    [2];
    logic [3:0]        pos_q    [2];
    logic [3:0]        pos_n    [2];
    logic [9:0]        tmr_q    [2];
    logic [9:0]        tmr_n    [2];
    logic [15:0]       prev_q   [2];
    logic [15:0]       paddle_q [2];
    logic [15:0]       paddle_n [2];
    logic              start_q, start_n;
    logic              game_reset_q, game_reset_n;
    logic              attract_q, attract_n;
    logic              att_now;
    logic signed [5:0] tgt_raw;
    logic [3:0]        tgt;

    // Lowest set row of the human bitmap, clamped so the AI paddle fits.
    function automatic logic [3:0] home_pos(input logic [15:0] v);
        logic [3:0] idx;
        idx = POS_MID;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        if (idx > POS_MAX) idx = POS_MAX;
        return idx;
    endfunction

    assign pin[0]  = bus.lpaddle_in;
    assign pin[1]  = bus.rpaddle_in;
    // Each AI only reacts while the ball is in its own half.
    assign gate[0] = (bus.ball_x <= 4'd7);
    assign gate[1] = (bus.ball_x >= 4'd8);

    always_comb begin
        tgt_raw = $signed({2'b00, bus.ball_y}) - HALF_LEN;
        if (tgt_raw < 6'sd0)
            tgt = 4'd0;
        else if (tgt_raw > POS_MAX_S)
            tgt = POS_MAX;
        else
            tgt = tgt_raw[3:0];
    end

    always_comb begin
        att_now = mode_q[0][0] & mode_q[1][0];
        for (int s = 0; s < 2; s++) begin
            mode_n[s] = mode_q[s];
            cnt_n[s]  = cnt_q[s];
            pos_n[s]  = pos_q[s];
            tmr_n[s]  = tmr_q[s];
            if (mode_q[s] == MODE_HUMAN) begin
                pos_n[s] = home_pos(pin[s]);
                tmr_n[s] = '0;
                if (pin[s] != prev_q[s])
                    cnt_n[s] = '0;
                else if (cnt_q[s] == IDLE_TC)
                    mode_n[s] = MODE_AUTO;
                else
                    cnt_n[s] = cnt_q[s] + 15'd1;
            end else if (pin[s] != prev_q[s]) begin
                mode_n[s] = MODE_HUMAN;
                cnt_n[s]  = '0;
                tmr_n[s]  = '0;
            end else if (tmr_q[s] == STEP_TC) begin
                tmr_n[s] = '0;
                if (gate[s]) begin
                    if (pos_q[s] < tgt)
                        pos_n[s] = pos_q[s] + 4'd1;
                    else if (pos_q[s] > tgt)
                        pos_n[s] = pos_q[s] - 4'd1;
                end
            end else begin
                tmr_n[s] = tmr_q[s] + 10'd1;
            end
        end

        // Start during attract, or racing attract entry, hands both sides
        // back to the players; otherwise it only restarts human idle timers.
        if (bus.start_in) begin
            if (att_now || (mode_n[0] == MODE_AUTO && mode_n[1] == MODE_AUTO)) begin
                for (int s = 0; s < 2; s++) begin
                    mode_n[s] = MODE_HUMAN;
                    cnt_n[s]  = '0;
                    tmr_n[s]  = '0;
                end
            end else begin
                for (int s = 0; s < 2; s++) begin
                    if (mode_q[s] == MODE_HUMAN) begin
                        mode_n[s] = MODE_HUMAN;
                        cnt_n[s]  = '0;
                    end
                end
            end
        end

        attract_n    = mode_n[0][0] & mode_n[1][0];
        // Entry pulse lets the game core skip its serve freeze.
        start_n      = (bus.start_in & ~att_now) | (attract_n & ~att_now);
        game_reset_n = att_now & ~attract_n;
        for (int s = 0; s < 2; s++) begin
            paddle_n[s] = (mode_n[s] == MODE_AUTO) ? (AI_MASK << pos_n[s]) : pin[s];
        end
    end

    always_ff @(posedge game_clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                mode_q[s]   <= MODE_HUMAN;
                cnt_q[s]    <= '0;
                pos_q[s]    <= POS_MID;
                tmr_q[s]    <= '0;
                prev_q[s]   <= '0;
                paddle_q[s] <= '0;
            end
            start_q      <= 1'b0;
            game_reset_q <= 1'b0;
            attract_q    <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                mode_q[s]   <= mode_n[s];
                cnt_q[s]    <= cnt_n[s];
                pos_q[s]    <= pos_n[s];
                tmr_q[s]    <= tmr_n[s];
                prev_q[s]   <= pin[s];
                paddle_q[s] <= paddle_n[s];
            end
            start_q      <= start_n;
            game_reset_q <= game_reset_n;
            attract_q    <= attract_n;
        end
    end

    assign bus.lpaddle    = paddle_q[0];
    assign bus.rpaddle    = paddle_q[1];
    assign bus.start      = start_q;
    assign bus.game_reset = game_reset_q;
    assign bus.l_auto     = mode_q[0][0];
    assign bus.r_auto     = mode_q[1][0];
    assign bus.attract    = attract_q;
endmodule
